// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: angle scaling, atan table, guard width and gain-compensation shifts.
package cordic_pkg;

   localparam int N_FRAC_DEF = 7;
   localparam int ITER_MAX   = 8;

   // Angles are in units of pi, so +/-0.5 pi is +/-2^(N_FRAC-1)
   localparam logic signed [N_FRAC_DEF:0] HALF       = 8'sh40;
   localparam logic signed [N_FRAC_DEF:0] MINUS_HALF = 8'shC0;

   // atan(2^-i)/pi at 16 fractional bits; rescaled to the port precision by atan_at()
   localparam int ATAN_Q16 [ITER_MAX] = '{16384, 9672, 5110, 2594, 1302, 652, 326, 163};

   // 1/K ~ v/2 + v/8 - v/64 - v/512
   localparam int COMP_ADD_SH [2] = '{1, 3};
   localparam int COMP_SUB_SH [2] = '{6, 9};

   typedef enum logic {S_IDLE, S_ROTATE} state_t;

   // Two guard bits above the sign: covers the K ~ 1.65 growth of a full-scale diagonal vector
   function automatic int guard_w(input int nfrac);
      return nfrac + 3;
   endfunction

   function automatic int atan_at(input int i, input int nfrac);
      return (ATAN_Q16[i] + (1 << (15 - nfrac))) >>> (16 - nfrac);
   endfunction

endpackage

// File: rtl/cordic_iterative_if.sv
// Sample handshake between the convergence stage, the CORDIC core and the wave-output logic.
interface cordic_iterative_if #(
   parameter int N_FRAC = 7
);
   logic signed [N_FRAC:0] x_i, y_i, z_i;
   logic                   data_in_valid_strobe_i;
   logic                   ready_o;
   logic signed [N_FRAC:0] x_o, y_o, z_o;
   logic                   data_out_valid_strobe_o;

   modport master (
      output x_i, y_i, z_i, data_in_valid_strobe_i,
      input  ready_o, x_o, y_o, z_o, data_out_valid_strobe_o
   );

   modport slave (
      input  x_i, y_i, z_i, data_in_valid_strobe_i,
      output ready_o, x_o, y_o, z_o, data_out_valid_strobe_o
   );
endinterface

// File: rtl/cordic_saturate.sv
// Signed clamp from W_IN bits down to W_OUT bits.
module cordic_saturate #(
   parameter int W_IN  = 10,
   parameter int W_OUT = 8
) (
   input  logic signed [W_IN-1:0]  i_d,
   output logic signed [W_OUT-1:0] o_q
);
   localparam logic signed [W_IN-1:0] MAX_V = W_IN'((1 << (W_OUT - 1)) - 1);
   localparam logic signed [W_IN-1:0] MIN_V = ~MAX_V;

   always_comb begin
      if (i_d > MAX_V)      o_q = MAX_V[W_OUT-1:0];
      else if (i_d < MIN_V) o_q = MIN_V[W_OUT-1:0];
      else                  o_q = i_d[W_OUT-1:0];
   end
endmodule

// File: rtl/cordic_iterative.sv
// Sequential rotation-mode CORDIC, one micro-rotation per clock.
// `CORDIC_GAIN_COMP_EN applies the 1/K shift-add correction to x/y in the final cycle.
module cordic_iterative
   import cordic_pkg::*;
#(
   parameter int N_FRAC = N_FRAC_DEF,
   parameter int N_ITER = 7
) (
   input logic              clk_i,
   input logic              rst_i,
   cordic_iterative_if.slave io
);
   localparam int         W    = guard_w(N_FRAC);
   localparam logic [2:0] LAST = 3'(N_ITER - 1);

   state_t                 r_state, w_state_nxt;
   logic [2:0]             r_iter;
   logic signed [W-1:0]    r_x, r_y, r_z;
   logic signed [W-1:0]    w_xs, w_ys, w_atan;
   logic signed [W-1:0]    w_x_nxt, w_y_nxt, w_z_nxt;
   logic signed [W-1:0]    w_x_fin, w_y_fin;
   logic signed [N_FRAC:0] w_x_sat, w_y_sat;
   logic                   w_accept, w_last, w_pos;

   assign io.ready_o = (r_state == S_IDLE);
   assign w_accept   = io.data_in_valid_strobe_i && (r_state == S_IDLE);
   assign w_last     = (r_state == S_ROTATE) && (r_iter == LAST);

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_accept) w_state_nxt = S_ROTATE;
         S_ROTATE: if (w_last)   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // d = +1 when the residual angle is non-negative
   assign w_pos   = ~r_z[W-1];
   assign w_xs    = r_x >>> r_iter;
   assign w_ys    = r_y >>> r_iter;
   assign w_atan  = W'(atan_at(int'(r_iter), N_FRAC));
   assign w_x_nxt = w_pos ? (r_x - w_ys)   : (r_x + w_ys);
   assign w_y_nxt = w_pos ? (r_y + w_xs)   : (r_y - w_xs);
   assign w_z_nxt = w_pos ? (r_z - w_atan) : (r_z + w_atan);

`ifdef CORDIC_GAIN_COMP_EN
   assign w_x_fin = (w_x_nxt >>> COMP_ADD_SH[0]) + (w_x_nxt >>> COMP_ADD_SH[1])
                  - (w_x_nxt >>> COMP_SUB_SH[0]) - (w_x_nxt >>> COMP_SUB_SH[1]);
   assign w_y_fin = (w_y_nxt >>> COMP_ADD_SH[0]) + (w_y_nxt >>> COMP_ADD_SH[1])
                  - (w_y_nxt >>> COMP_SUB_SH[0]) - (w_y_nxt >>> COMP_SUB_SH[1]);
`else
   assign w_x_fin = w_x_nxt;
   assign w_y_fin = w_y_nxt;
`endif

   cordic_saturate #(.W_IN(W), .W_OUT(N_FRAC + 1)) u_sat_x (.i_d(w_x_fin), .o_q(w_x_sat));
   cordic_saturate #(.W_IN(W), .W_OUT(N_FRAC + 1)) u_sat_y (.i_d(w_y_fin), .o_q(w_y_sat));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_iter                     <= '0;
         r_x                        <= '0;
         r_y                        <= '0;
         r_z                        <= '0;
         io.x_o                     <= '0;
         io.y_o                     <= '0;
         io.z_o                     <= '0;
         io.data_out_valid_strobe_o <= 1'b0;
      end else begin
         io.data_out_valid_strobe_o <= w_last;
         if (w_accept) begin
            r_iter <= '0;
            r_x    <= {{(W - N_FRAC - 1){io.x_i[N_FRAC]}}, io.x_i};
            r_y    <= {{(W - N_FRAC - 1){io.y_i[N_FRAC]}}, io.y_i};
            r_z    <= {{(W - N_FRAC - 1){io.z_i[N_FRAC]}}, io.z_i};
         end else if (r_state == S_ROTATE) begin
            r_iter <= r_iter + 3'd1;
            r_x    <= w_x_nxt;
            r_y    <= w_y_nxt;
            r_z    <= w_z_nxt;
         end
         if (w_last) begin
            io.x_o <= w_x_sat;
            io.y_o <= w_y_sat;
            io.z_o <= w_z_nxt[N_FRAC:0];
         end
      end
   end
endmodule

// File: tb/tb_cordic_iterative.sv
// Directed bench for cordic_iterative (N_FRAC=7, N_ITER=7); expected results hand-traced per iteration.
`timescale 1ns/1ps
module tb_cordic_iterative;
   import cordic_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   cordic_iterative_if #(.N_FRAC(7)) bus ();

   cordic_iterative #(.N_FRAC(7), .N_ITER(7)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .io    (bus)
   );

   always #5 clk = ~clk;

   // Vectors: A=(77,0,0) B=(127,127,0) C=(-128,0,0) D=(77,0,+0.25pi) E=(77,0,-0.5pi)
   logic [7:0] vx [5] = '{8'd77, 8'd127, 8'h80, 8'd77, 8'd77};
   logic [7:0] vy [5] = '{8'd0,  8'd127, 8'd0,  8'd0,  8'd0};
   logic [7:0] vz [5] = '{8'h00, 8'h00,  8'h00, 8'h20, 8'hC0};
   logic [7:0] ez [5] = '{8'hFF, 8'hFF,  8'hFF, 8'hFF, 8'hFF};
`ifdef CORDIC_GAIN_COMP_EN
   logic [7:0] ex [5] = '{8'd77, 8'd127, 8'h80, 8'd52, 8'h00};
   logic [7:0] ey [5] = '{8'd0,  8'd127, 8'h00, 8'd56, 8'hB3};
`else
   logic [7:0] ex [5] = '{8'd126, 8'd127, 8'h80, 8'd87, 8'hFF};
   logic [7:0] ey [5] = '{8'd1,   8'd127, 8'hFF, 8'd92, 8'h81};
`endif

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
      bus.x_i = x;
      bus.y_i = y;
      bus.z_i = z;
      bus.data_in_valid_strobe_i = 1'b1;
      tick();
      bus.data_in_valid_strobe_i = 1'b0;
   endtask

   // Cycles from the input strobe to the output strobe; -1 on timeout
   task automatic wait_out(output int lat);
      lat = 1;
      while (!bus.data_out_valid_strobe_o && lat < 40) begin
         tick();
         lat++;
      end
      if (!bus.data_out_valid_strobe_o) lat = -1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.ready_o); end
      checks++; if (bus.x_o !== 8'h00) begin errors++; $display("FAIL reset_x: got %h want 00", bus.x_o); end
      checks++; if (bus.y_o !== 8'h00) begin errors++; $display("FAIL reset_y: got %h want 00", bus.y_o); end
      checks++; if (bus.z_o !== 8'h00) begin errors++; $display("FAIL reset_z: got %h want 00", bus.z_o); end
      checks++; if (bus.data_out_valid_strobe_o !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", bus.data_out_valid_strobe_o); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_latency();
      int lat;
      drive(vx[0], vy[0], vz[0]);
      wait_out(lat);
      checks++; if (lat != 8) begin errors++; $display("FAIL latency: got %0d want 8", lat); end
      checks++; if (bus.x_o !== ex[0]) begin errors++; $display("FAIL A_x: got %0d want %0d", $signed(bus.x_o), $signed(ex[0])); end
      checks++; if (bus.y_o !== ey[0]) begin errors++; $display("FAIL A_y: got %0d want %0d", $signed(bus.y_o), $signed(ey[0])); end
      checks++; if (bus.z_o !== ez[0]) begin errors++; $display("FAIL A_z: got %0d want %0d", $signed(bus.z_o), $signed(ez[0])); end
      tick();
      checks++; if (bus.data_out_valid_strobe_o !== 1'b0) begin errors++; $display("FAIL strobe_width: got %b want 0", bus.data_out_valid_strobe_o); end
      checks++; if (bus.x_o !== ex[0]) begin errors++; $display("FAIL hold_x: got %0d want %0d", $signed(bus.x_o), $signed(ex[0])); end
   endtask

   task automatic test_vectors();
      int lat;
      for (int v = 1; v < 5; v++) begin
         drive(vx[v], vy[v], vz[v]);
         wait_out(lat);
         checks++; if (lat != 8) begin errors++; $display("FAIL vec%0d_latency: got %0d want 8", v, lat); end
         checks++; if (bus.x_o !== ex[v]) begin errors++; $display("FAIL vec%0d_x: got %0d want %0d", v, $signed(bus.x_o), $signed(ex[v])); end
         checks++; if (bus.y_o !== ey[v]) begin errors++; $display("FAIL vec%0d_y: got %0d want %0d", v, $signed(bus.y_o), $signed(ey[v])); end
         checks++; if (bus.z_o !== ez[v]) begin errors++; $display("FAIL vec%0d_z: got %0d want %0d", v, $signed(bus.z_o), $signed(ez[v])); end
      end
   endtask

   task automatic test_drop();
      int cyc, pulses, at_cyc;
      logic [7:0] gx, gy;
      pulses = 0; at_cyc = -1; gx = 8'h00; gy = 8'h00;
      drive(vx[0], vy[0], vz[0]);
      tick();
      tick();
      checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b want 0", bus.ready_o); end
      drive(vx[1], vy[1], vz[1]);
      cyc = 4;
      for (int k = 0; k < 20; k++) begin
         if (bus.data_out_valid_strobe_o) begin
            pulses++;
            if (at_cyc < 0) begin at_cyc = cyc; gx = bus.x_o; gy = bus.y_o; end
         end
         tick();
         cyc++;
      end
      checks++; if (pulses != 1) begin errors++; $display("FAIL drop_pulses: got %0d want 1", pulses); end
      checks++; if (at_cyc != 8) begin errors++; $display("FAIL drop_latency: got %0d want 8", at_cyc); end
      checks++; if (gx !== ex[0]) begin errors++; $display("FAIL drop_x: got %0d want %0d", $signed(gx), $signed(ex[0])); end
      checks++; if (gy !== ey[0]) begin errors++; $display("FAIL drop_y: got %0d want %0d", $signed(gy), $signed(ey[0])); end
   endtask

   task automatic test_back_to_back();
      int lat;
      drive(vx[0], vy[0], vz[0]);
      wait_out(lat);
      checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", bus.ready_o); end
      drive(vx[3], vy[3], vz[3]);
      wait_out(lat);
      checks++; if (lat != 8) begin errors++; $display("FAIL b2b_latency: got %0d want 8", lat); end
      checks++; if (bus.x_o !== ex[3]) begin errors++; $display("FAIL b2b_x: got %0d want %0d", $signed(bus.x_o), $signed(ex[3])); end
      checks++; if (bus.y_o !== ey[3]) begin errors++; $display("FAIL b2b_y: got %0d want %0d", $signed(bus.y_o), $signed(ey[3])); end
   endtask

   task automatic test_mid_reset();
      int lat, pulses;
      pulses = 0;
      drive(vx[3], vy[3], vz[3]);
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (bus.x_o !== 8'h00) begin errors++; $display("FAIL midrst_x: got %h want 00", bus.x_o); end
      checks++; if (bus.y_o !== 8'h00) begin errors++; $display("FAIL midrst_y: got %h want 00", bus.y_o); end
      checks++; if (bus.z_o !== 8'h00) begin errors++; $display("FAIL midrst_z: got %h want 00", bus.z_o); end
      checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", bus.ready_o); end
      for (int k = 0; k < 12; k++) begin
         if (bus.data_out_valid_strobe_o) pulses++;
         tick();
      end
      checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_pulses: got %0d want 0", pulses); end
      drive(vx[0], vy[0], vz[0]);
      wait_out(lat);
      checks++; if (lat != 8) begin errors++; $display("FAIL post_rst_latency: got %0d want 8", lat); end
      checks++; if (bus.x_o !== ex[0]) begin errors++; $display("FAIL post_rst_x: got %0d want %0d", $signed(bus.x_o), $signed(ex[0])); end
   endtask

`ifdef CORDIC_GAIN_COMP_EN
   task automatic test_comp_quarter();
      int lat, xa, ya, za;
      drive(8'd127, 8'd0, 8'h20);
      wait_out(lat);
      xa = $signed(bus.x_o); ya = $signed(bus.y_o); za = $signed(bus.z_o);
      checks++; if (xa < 88 || xa > 92) begin errors++; $display("FAIL comp_q_x: got %0d want 88..92", xa); end
      checks++; if (ya < 88 || ya > 92) begin errors++; $display("FAIL comp_q_y: got %0d want 88..92", ya); end
      checks++; if (za < -2 || za > 2) begin errors++; $display("FAIL comp_q_z: got %0d want -2..2", za); end
      drive(8'd127, 8'd0, 8'hE0);
      wait_out(lat);
      ya = $signed(bus.y_o);
      checks++; if (ya < -92 || ya > -88) begin errors++; $display("FAIL comp_nq_y: got %0d want -92..-88", ya); end
   endtask

   task automatic test_comp_sweep();
      int lat, xa, ya;
      real rx, ry;
      for (int z = int'(MINUS_HALF); z <= int'(HALF); z++) begin
         drive(8'd127, 8'd0, 8'(z));
         wait_out(lat);
         xa = $signed(bus.x_o);
         ya = $signed(bus.y_o);
         rx = 127.0 * $cos(z * 3.14159265358979 / 128.0);
         ry = 127.0 * $sin(z * 3.14159265358979 / 128.0);
         checks++; if (xa - rx > 3.0 || rx - xa > 3.0) begin errors++; $display("FAIL sweep_x z=%0d: got %0d want %0.2f+-3", z, xa, rx); end
         checks++; if (ya - ry > 3.0 || ry - ya > 3.0) begin errors++; $display("FAIL sweep_y z=%0d: got %0d want %0.2f+-3", z, ya, ry); end
      end
   endtask
`endif

   initial begin
      bus.x_i = '0;
      bus.y_i = '0;
      bus.z_i = '0;
      bus.data_in_valid_strobe_i = 1'b0;
      test_reset();
      test_latency();
      test_vectors();
      test_drop();
      test_back_to_back();
      test_mid_reset();
`ifdef CORDIC_GAIN_COMP_EN
      test_comp_quarter();
      test_comp_sweep();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
